// File: rtl/traffic_conflict_monitor_pkg.sv
// Shared types, fault codes and lamp decode for the lamp-side traffic safety monitor.
package traffic_mon_pkg;

  typedef enum logic [1:0] {RED, YEL, GRN, BAD} lamp_state_t;

  typedef enum logic [1:0] {MON_INIT, MON_RUN, MON_FAULT} mon_state_t;

  localparam logic [2:0] FLT_NONE      = 3'd0;
  localparam logic [2:0] FLT_CONFLICT  = 3'd1;
  localparam logic [2:0] FLT_LAMP      = 3'd2;
  localparam logic [2:0] FLT_SEQ       = 3'd3;
  localparam logic [2:0] FLT_SHORT_YEL = 3'd4;
  localparam logic [2:0] FLT_GREEN_TO  = 3'd5;

  // Exactly one lamp lit is legal; dark or multi-hot heads are BAD.
  function automatic lamp_state_t decode_lamp(input logic r, input logic y, input logic g);
    case ({r, y, g})
      3'b100:  return RED;
      3'b010:  return YEL;
      3'b001:  return GRN;
      default: return BAD;
    endcase
  endfunction

endpackage

// File: rtl/traffic_conflict_monitor_if.sv
// Lamp sample inputs, fault clear request and status outputs of the conflict monitor.
interface traffic_conflict_monitor_if;
  logic       ns_red, ns_yellow, ns_green;
  logic       ew_red, ew_yellow, ew_green;
  logic       clear_fault;
  logic       fault;
  logic [2:0] fault_code;
  logic       fault_dir;
  logic       flash_red;
  logic [7:0] ns_phases;
  logic [7:0] ew_phases;

  modport master (
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, clear_fault,
    input  fault, fault_code, fault_dir, flash_red, ns_phases, ew_phases
  );

  modport slave (
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, clear_fault,
    output fault, fault_code, fault_dir, flash_red, ns_phases, ew_phases
  );
endinterface

// File: rtl/traffic_conflict_monitor_lamp_dwell_tracker.sv
// Per-direction previous-state and dwell tracking with sequence/timing violation flags.
module lamp_dwell_tracker
  import traffic_mon_pkg::*;
#(
  parameter int YELLOW_MIN = 4,
  parameter int GREEN_MAX  = 32,
  parameter int DW         = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  lamp_state_t state_i,
  input  logic        init_i,
  output logic        bad_o,
  output logic        seq_err_o,
  output logic        short_yellow_o,
  output logic        timeout_o,
  output logic        phase_done_o
);

  localparam logic [DW-1:0] YEL_MIN_C = DW'(YELLOW_MIN);
  localparam logic [DW-1:0] GRN_MAX_C = DW'(GREEN_MAX);
  localparam logic [DW-1:0] DWELL_SAT = {DW{1'b1}};
  localparam logic [DW-1:0] DWELL_ONE = DW'(1);

  lamp_state_t   prev_q;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          chk;

  assign chk = !init_i;

  always_comb begin
    dwell_d = dwell_q;
    if (init_i || state_i != prev_q) dwell_d = DWELL_ONE;
    else if (dwell_q != DWELL_SAT)   dwell_d = dwell_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= RED;
      dwell_q <= '0;
    end else begin
      prev_q  <= state_i;
      dwell_q <= dwell_d;
    end
  end

  // Flags look at the state and dwell stored at the previous edge.
  assign bad_o          = (state_i == BAD);
  assign seq_err_o      = chk && ((prev_q == GRN && state_i == RED) ||
                                  (prev_q == YEL && state_i == GRN));
  assign short_yellow_o = chk && prev_q == YEL && state_i != YEL && dwell_q < YEL_MIN_C;
  assign timeout_o      = chk && prev_q == GRN && state_i == GRN && dwell_q == GRN_MAX_C;
  assign phase_done_o   = chk && prev_q == YEL && state_i == RED && dwell_q >= YEL_MIN_C;

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Lamp-side safety monitor: conflict detection, violation priority and fault latching FSM.
module traffic_conflict_monitor
  import traffic_mon_pkg::*;
#(
  parameter int YELLOW_MIN   = 4,
  parameter int NS_GREEN_MAX = 32,
  parameter int EW_GREEN_MAX = 16,
  parameter int DW           = 6
) (
  input logic                        clk,
  input logic                        rst,
  traffic_conflict_monitor_if.slave  mon_if
);

  lamp_state_t ns_st, ew_st;
  mon_state_t  state_q;
  logic        fault_q, dir_q;
  logic [2:0]  code_q;
  logic [7:0]  ns_ph_q, ew_ph_q;
  logic        init_chk;
  logic        ns_bad, ns_seq, ns_sy, ns_to, ns_done;
  logic        ew_bad, ew_seq, ew_sy, ew_to, ew_done;
  logic        conflict, viol_dir;
  logic [2:0]  viol_code;

  assign ns_st    = decode_lamp(mon_if.ns_red, mon_if.ns_yellow, mon_if.ns_green);
  assign ew_st    = decode_lamp(mon_if.ew_red, mon_if.ew_yellow, mon_if.ew_green);
  assign init_chk = (state_q != MON_RUN);

  lamp_dwell_tracker #(.YELLOW_MIN(YELLOW_MIN), .GREEN_MAX(NS_GREEN_MAX), .DW(DW)) u_ns (
    .clk(clk), .rst(rst), .state_i(ns_st), .init_i(init_chk),
    .bad_o(ns_bad), .seq_err_o(ns_seq), .short_yellow_o(ns_sy),
    .timeout_o(ns_to), .phase_done_o(ns_done)
  );

  lamp_dwell_tracker #(.YELLOW_MIN(YELLOW_MIN), .GREEN_MAX(EW_GREEN_MAX), .DW(DW)) u_ew (
    .clk(clk), .rst(rst), .state_i(ew_st), .init_i(init_chk),
    .bad_o(ew_bad), .seq_err_o(ew_seq), .short_yellow_o(ew_sy),
    .timeout_o(ew_to), .phase_done_o(ew_done)
  );

  assign conflict = (ns_st == YEL || ns_st == GRN) && (ew_st == YEL || ew_st == GRN);

  always_comb begin
    viol_code = FLT_NONE;
    viol_dir  = 1'b0;
    if      (conflict) viol_code = FLT_CONFLICT;
    else if (ns_bad)   viol_code = FLT_LAMP;
    else if (ew_bad)   begin viol_code = FLT_LAMP;      viol_dir = 1'b1; end
    else if (ns_seq)   viol_code = FLT_SEQ;
    else if (ew_seq)   begin viol_code = FLT_SEQ;       viol_dir = 1'b1; end
    else if (ns_sy)    viol_code = FLT_SHORT_YEL;
    else if (ew_sy)    begin viol_code = FLT_SHORT_YEL; viol_dir = 1'b1; end
    else if (ns_to)    viol_code = FLT_GREEN_TO;
    else if (ew_to)    begin viol_code = FLT_GREEN_TO;  viol_dir = 1'b1; end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MON_INIT;
      fault_q <= 1'b0;
      code_q  <= FLT_NONE;
      dir_q   <= 1'b0;
      ns_ph_q <= '0;
      ew_ph_q <= '0;
    end else begin
      case (state_q)
        MON_INIT, MON_RUN: begin
          if (viol_code != FLT_NONE) begin
            state_q <= MON_FAULT;
            fault_q <= 1'b1;
            code_q  <= viol_code;
            dir_q   <= viol_dir;
          end else begin
            state_q <= MON_RUN;
            // Phase flags are already suppressed while in MON_INIT.
            if (ns_done && ns_ph_q != 8'hFF) ns_ph_q <= ns_ph_q + 8'd1;
            if (ew_done && ew_ph_q != 8'hFF) ew_ph_q <= ew_ph_q + 8'd1;
          end
        end
        MON_FAULT: begin
          if (mon_if.clear_fault && ns_st == RED && ew_st == RED) begin
            state_q <= MON_INIT;
            fault_q <= 1'b0;
            code_q  <= FLT_NONE;
            dir_q   <= 1'b0;
          end
        end
        default: state_q <= MON_INIT;
      endcase
    end
  end

  assign mon_if.fault      = fault_q;
  assign mon_if.flash_red  = fault_q;
  assign mon_if.fault_code = code_q;
  assign mon_if.fault_dir  = dir_q;
  assign mon_if.ns_phases  = ns_ph_q;
  assign mon_if.ew_phases  = ew_ph_q;

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Independent safety monitor on the lamp side of the intersection controller: samples the six NS/EW lamp outputs every clk (1 clk = 1 s, same time base as the phase counters).
- Checks lamp validity, cross-direction conflict, green→yellow→red sequencing and phase timing.
- On the first violation it latches a fault code and direction, and raises flash_red to force the intersection into all-red flash.
- Also counts completed phases per direction for status reporting.

Parameters:
- YELLOW_MIN, 4, minimum yellow dwell in cycles.
- NS_GREEN_MAX, 32, maximum NS green dwell in cycles.
- EW_GREEN_MAX, 16, maximum EW green dwell in cycles.
- DW, 6, dwell counter width; must satisfy 2^DW-1 > max(NS_GREEN_MAX, EW_GREEN_MAX).

Ports:
- clk  in  1  system clock, 1 s tick.
- rst  in  1  reset, asynchronous, active-high.
- ns_red/ns_yellow/ns_green  in  1 each  NS lamp drives from the controller.
- ew_red/ew_yellow/ew_green  in  1 each  EW lamp drives from the controller.
- clear_fault  in  1  single-cycle request to clear a latched fault.
- fault  out  1  fault latched.
- fault_code  out  3  0 none, 1 conflict, 2 bad lamp pattern, 3 bad sequence, 4 short yellow, 5 green timeout.
- fault_dir  out  1  0 = NS, 1 = EW (0 for conflict).
- flash_red  out  1  equals fault; override request to the lamp drivers.
- ns_phases  out  8  completed NS phases, saturating.
- ew_phases  out  8  completed EW phases, saturating.

Behaviour:
- Reset, async, active-high:
  - fault=0, fault_code=0, fault_dir=0, flash_red=0, ns_phases=0, ew_phases=0.
  - Dwell counters = 0. Previous-state registers = RED. FSM = MON_INIT.
- Decode per direction each posedge from the raw inputs:
  - RED=100, YEL=010, GRN=001 (bit order r,y,g).
  - Any other pattern, including 000 and multi-hot, is BAD.
- Dwell counter per direction:
  - Set to 1 when the decoded state differs from the previous state; otherwise increments, saturating at 2^DW-1.
- FSM:
  - MON_INIT: first posedge after reset captures states, sets dwell=1, performs no transition or timing checks, then goes to MON_RUN. BAD or conflict is still flagged in MON_INIT.
  - MON_RUN: all checks active. Any violation goes to MON_FAULT.
  - MON_FAULT: outputs frozen, phase counters frozen. When clear_fault=1 and both directions decode RED at that edge: fault/code/dir clear, next state MON_INIT. clear_fault is ignored otherwise.
- Checks at posedge, with "prev" = the state stored at the previous edge:
  - Conflict: both directions decode YEL or GRN.
  - Lamp: a direction decodes BAD.
  - Sequence: prev GRN → RED, or prev YEL → GRN.
  - Short yellow: prev YEL → non-YEL while prev dwell < YELLOW_MIN.
  - Green timeout: GRN continues while prev dwell == GREEN_MAX for that direction, i.e. the fault fires on dwell cycle GREEN_MAX+1.
- Priority for simultaneous violations: conflict > lamp > sequence > short yellow > timeout; NS before EW within a class. Only the highest-priority violation is latched.
- Latency: a violation sampled at edge k gives fault=1 immediately after edge k (registered, 1 cycle from the input change).
- Phase count: ns_phases/ew_phases increment on a legal YEL→RED transition in MON_RUN. They saturate at 255 and are not cleared by clear_fault.
- Reset mid-fault returns everything to reset values asynchronously.

Decomposition:
- Package traffic_mon_pkg holds:
  - lamp_state_t {RED, YEL, GRN, BAD}
  - mon_state_t {MON_INIT, MON_RUN, MON_FAULT}
  - fault code constants FLT_NONE..FLT_GREEN_TO
  - function decode_lamp(r,y,g).
- One sub-module, lamp_dwell_tracker, instantiated twice (NS, EW) with a GREEN_MAX parameter. It holds the previous state and dwell counter and emits per-direction flags: bad, seq_err, short_yellow, timeout, phase_done.
- Top level does conflict detection, priority encoding and the FSM.

Test Plan:
- Legal cycle: NS GRN 32 cycles → YEL 4 → RED with EW RED, then EW GRN 16 → YEL 4 → RED. Required: fault stays 0; ns_phases=1 and ew_phases=1 after the respective YEL→RED edges.
- Conflict: NS GRN and EW switched to GRN at edge k. Required: fault=1, code=1, dir=0, flash_red=1 after edge k.
- Short yellow plus clear: NS YEL for 3 cycles then RED. Required: code=4, dir=0. Then clear_fault with both RED. Required: fault=0, MON_INIT, and ns_phases unchanged at its prior value.
- Timeout: EW GRN held 17 cycles. Required: code=5, dir=1 on the 17th dwell edge; none at 16.
- Simultaneous violations: NS pattern 110 and EW GRN→RED at the same edge. Required: code=2 (lamp beats sequence), dir=0. clear_fault while EW is not RED is ignored.
- Async reset: assert rst mid-MON_FAULT between edges. Required: all outputs 0 immediately. First post-reset edge with NS YEL must not flag a sequence or short-yellow fault.
